ipa_gcm_ctrl: RTL

IPA_GCM_CTRL -- requirements
Module: ipa_gcm_ctrl

---
 rtl/ipa_gcm_ctrl_if.sv | 31 +++
 rtl/ipa_gcm_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ipa_gcm_ctrl_if.sv
// ipa_gcm_ctrl_if: config slave, GCM bank read and CGRA context-write buses of ipa_gcm_ctrl.
interface ipa_gcm_ctrl_if #(
    parameter int NB_GCM_BANKS   = 2,
    parameter int ADDR_MEM_WIDTH = 12,
    parameter int CFG_ADDR_WIDTH = 23
);
    logic                                   cfg_req_i;
    logic [2:0]                             cfg_add_i;
    logic                                   cfg_wen_i;
    logic [31:0]                            cfg_wdata_i;
    logic                                   cfg_gnt_o;
    logic                                   cfg_r_valid_o;
    logic [31:0]                            cfg_r_rdata_o;
    logic [NB_GCM_BANKS-1:0]                gcm_req_o;
    logic [NB_GCM_BANKS*ADDR_MEM_WIDTH-1:0] gcm_add_o;
    logic [NB_GCM_BANKS*32-1:0]             gcm_rdata_i;
    logic                                   cgra_we_o;
    logic [CFG_ADDR_WIDTH-1:0]              cgra_addr_o;
    logic [NB_GCM_BANKS*32-1:0]             cgra_data_o;

    modport slave (
        input  cfg_req_i, cfg_add_i, cfg_wen_i, cfg_wdata_i, gcm_rdata_i,
        output cfg_gnt_o, cfg_r_valid_o, cfg_r_rdata_o, gcm_req_o, gcm_add_o,
               cgra_we_o, cgra_addr_o, cgra_data_o
    );
    modport master (
        output cfg_req_i, cfg_add_i, cfg_wen_i, cfg_wdata_i, gcm_rdata_i,
        input  cfg_gnt_o, cfg_r_valid_o, cfg_r_rdata_o, gcm_req_o, gcm_add_o,
               cgra_we_o, cgra_addr_o, cgra_data_o
    );
endinterface

// File: rtl/ipa_gcm_ctrl.sv
// ipa_gcm_ctrl: copies a context from the GCM banks into CGRA config memory, runs the CGRA
// until the selected PEs report end of execution, and raises an interrupt.
module ipa_gcm_ctrl #(
    parameter int NB_GCM_BANKS   = 2,
    parameter int NB_PE          = 16,
    parameter int ADDR_MEM_WIDTH = 12,
    parameter int CFG_ADDR_WIDTH = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    ipa_gcm_ctrl_if.slave    bus,
    output logic             dma_hold_o,
    output logic             cgra_exec_en_o,
    input  logic [NB_PE-1:0] end_exec_i,
    output logic             busy_o,
    output logic             irq_o
);
    localparam int AW = ADDR_MEM_WIDTH;
    localparam int CW = CFG_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EXEC, DONE} state_t;

    state_t           state;
    logic [AW-1:0]    ctx_base, gcm_add;
    logic [15:0]      ctx_len, beat, beat_nx;
    logic [CW-1:0]    dst_base, cgra_addr;
    logic             mode, done, err, gcm_req, cgra_we, r_valid;
    logic [31:0]      r_rdata, rd_val;
    logic [NB_PE-1:0] pe_mask, mask_nx;
    logic             wr, rd, start, abort, st_rd, hit;

    always_comb begin
        wr      = bus.cfg_req_i && !bus.cfg_wen_i;
        rd      = bus.cfg_req_i && bus.cfg_wen_i;
        start   = wr && bus.cfg_add_i == 3'd0 && bus.cfg_wdata_i == 32'd1;
        abort   = wr && bus.cfg_add_i == 3'd0 && bus.cfg_wdata_i == 32'd2;
        st_rd   = rd && bus.cfg_add_i == 3'd1;
        mask_nx = pe_mask | end_exec_i;
        hit     = mode ? &mask_nx : |mask_nx;
        beat_nx = beat + 16'd1;
        rd_val  = bus.cfg_add_i == 3'd1 ? {29'd0, err, done, busy_o} :
                  bus.cfg_add_i == 3'd2 ? 32'(ctx_base) :
                  bus.cfg_add_i == 3'd3 ? 32'(ctx_len) :
                  bus.cfg_add_i == 3'd4 ? 32'(dst_base) :
                  bus.cfg_add_i == 3'd5 ? 32'(mode) : 32'd0;
    end

    assign bus.cfg_gnt_o     = bus.cfg_req_i;
    assign bus.cfg_r_valid_o = r_valid;
    assign bus.cfg_r_rdata_o = r_rdata;
    assign bus.gcm_req_o     = {NB_GCM_BANKS{gcm_req}};
    assign bus.gcm_add_o     = {NB_GCM_BANKS{gcm_add}};
    assign bus.cgra_we_o     = cgra_we;
    assign bus.cgra_addr_o   = cgra_addr;

    // Read data arrives one cycle after the request, i.e. exactly in the cgra_we cycle.
    for (genvar g = 0; g < NB_GCM_BANKS; g++) begin : g_swap
        assign bus.cgra_data_o[(NB_GCM_BANKS-1-g)*32 +: 32] = cgra_we ? bus.gcm_rdata_i[g*32 +: 32] : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            ctx_base       <= '0;
            ctx_len        <= '0;
            dst_base       <= '0;
            mode           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            beat           <= '0;
            pe_mask        <= '0;
            gcm_req        <= 1'b0;
            gcm_add        <= '0;
            cgra_we        <= 1'b0;
            cgra_addr      <= '0;
            r_valid        <= 1'b0;
            r_rdata        <= '0;
            dma_hold_o     <= 1'b0;
            cgra_exec_en_o <= 1'b0;
            busy_o         <= 1'b0;
            irq_o          <= 1'b0;
        end else begin
            r_valid <= bus.cfg_req_i;
            r_rdata <= rd ? rd_val : 32'd0;
            if (wr && !busy_o && bus.cfg_add_i == 3'd2) ctx_base <= bus.cfg_wdata_i[AW-1:0];
            if (wr && !busy_o && bus.cfg_add_i == 3'd3) ctx_len <= bus.cfg_wdata_i[15:0];
            if (wr && bus.cfg_add_i == 3'd4) dst_base <= bus.cfg_wdata_i[CW-1:0];
            if (wr && !busy_o && bus.cfg_add_i == 3'd5) mode <= bus.cfg_wdata_i[0];
            // Clear-on-read sits before the FSM so any set in the same cycle wins.
            if (st_rd) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            gcm_req   <= 1'b0;
            gcm_add   <= '0;
            cgra_we   <= 1'b0;
            cgra_addr <= '0;
            irq_o     <= 1'b0;
            if (abort && state != IDLE) begin
                state          <= IDLE;
                dma_hold_o     <= 1'b0;
                cgra_exec_en_o <= 1'b0;
                busy_o         <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && ctx_len != 16'd0) begin
                        state      <= FETCH;
                        beat       <= '0;
                        gcm_req    <= 1'b1;
                        gcm_add    <= ctx_base;
                        dma_hold_o <= 1'b1;
                        busy_o     <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        pe_mask    <= '0;
                    end
                    FETCH: begin
                        cgra_we   <= 1'b1;
                        cgra_addr <= dst_base + CW'(beat);
                        if (beat == ctx_len - 16'd1) state <= DRAIN;
                        else begin
                            beat    <= beat_nx;
                            gcm_req <= 1'b1;
                            gcm_add <= ctx_base + AW'(beat_nx);
                        end
                    end
                    DRAIN: begin
                        state          <= EXEC;
                        dma_hold_o     <= 1'b0;
                        cgra_exec_en_o <= 1'b1;
                    end
                    EXEC: begin
                        pe_mask <= mask_nx;
                        if (hit) begin
                            state          <= DONE;
                            cgra_exec_en_o <= 1'b0;
                            done           <= 1'b1;
                            irq_o          <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
                if (start && (state != IDLE || ctx_len == 16'd0)) begin
                    err   <= 1'b1;
                    irq_o <= 1'b1;
                end
            end
        end
    end
endmodule
